// File: rtl/ifft_dac_playback_if.sv
// AXI-Stream slave bundle carrying IFFT output samples into the playback stage.
// Real part in tdata[IN_WIDTH-1:0]; the upper half (imaginary) is unused.
interface ifft_dac_playback_if #(
    parameter int IN_WIDTH = 16
) ();
    logic [2*IN_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ifft_dac_playback.sv
// Captures IFFT frames into a ping-pong buffer and replays the active frame to
// the DAC, converting samples to offset binary (round, shift, saturate) on write.
module ifft_dac_playback #(
    parameter int FFT_LEN   = 256,
    parameter int IN_WIDTH  = 16,
    parameter int DAC_WIDTH = 12,
    parameter int SHIFT     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ifft_dac_playback_if.slave   s_axis,
    input  logic                 enable,
    output logic [DAC_WIDTH-1:0] dac_data,
    output logic                 active,
    output logic [15:0]          frame_count,
    output logic                 len_err
);
    localparam int IDX_W = $clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] RND    = (IN_WIDTH+1)'(2**(SHIFT-1));
    localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'(2**(DAC_WIDTH-1) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_LO = ~SAT_HI;

    typedef enum logic {FILL, WAIT_SWAP} state_t;

    state_t               state;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 wr_bank;
    logic                 rd_bank;
    logic                 tready_r;
    logic                 hs;
    logic                 play;
    logic                 swap;
    logic                 vld_p0;
    logic [DAC_WIDTH-1:0] ram_q_p0;
    logic [DAC_WIDTH-1:0] mem [2*FFT_LEN];
    logic                 unused_imag;

    function automatic logic signed [IN_WIDTH:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] ext;
        ext = {x[IN_WIDTH-1], x};
        return (ext + RND) >>> SHIFT;
    endfunction

    function automatic logic [DAC_WIDTH-1:0] saturate_ob(input logic signed [IN_WIDTH:0] t);
        logic [DAC_WIDTH-1:0] y;
        if (t > SAT_HI)      y = SAT_HI[DAC_WIDTH-1:0];
        else if (t < SAT_LO) y = SAT_LO[DAC_WIDTH-1:0];
        else                 y = t[DAC_WIDTH-1:0];
        return {~y[DAC_WIDTH-1], y[DAC_WIDTH-2:0]};
    endfunction

    assign rd_bank        = ~wr_bank;
    assign hs             = s_axis.tvalid && tready_r;
    assign play           = active && enable;
    // While playing, a new bank may only take over at the wrap to stay seamless.
    assign swap           = (state == WAIT_SWAP) && (!play || rd_idx == LAST_IDX);
    assign s_axis.tready  = tready_r;
    assign unused_imag    = ^s_axis.tdata[2*IN_WIDTH-1:IN_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            tready_r    <= 1'b0;
            active      <= 1'b0;
            frame_count <= '0;
            len_err     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    tready_r <= 1'b1;
                    if (hs) begin
                        if (s_axis.tlast && wr_idx == LAST_IDX) begin
                            state    <= WAIT_SWAP;
                            tready_r <= 1'b0;
                        end else if (s_axis.tlast || wr_idx == LAST_IDX) begin
                            len_err <= 1'b1;
                            wr_idx  <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (swap) begin
                        state       <= FILL;
                        tready_r    <= 1'b1;
                        wr_bank     <= ~wr_bank;
                        wr_idx      <= '0;
                        active      <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Stage p0: convert-and-write port, synchronous read of the playback bank
    always_ff @(posedge clk) begin
        if (hs)
            mem[{wr_bank, wr_idx}] <= saturate_ob(round_shift(s_axis.tdata[IN_WIDTH-1:0]));
        ram_q_p0 <= mem[{rd_bank, rd_idx}];
    end

    // Stage p1: output register, midscale whenever the read was not a playback read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx   <= '0;
            vld_p0   <= 1'b0;
            dac_data <= MIDSCALE;
        end else begin
            rd_idx   <= play ? rd_idx + 1'b1 : '0;
            vld_p0   <= play;
            dac_data <= vld_p0 ? ram_q_p0 : MIDSCALE;
        end
    end
endmodule

// File: tb/tb_ifft_dac_playback.sv
// Scoreboard bench for ifft_dac_playback: frames are driven on the stream and the
// expected DAC sequence is queued, then popped against dac_data each clock.
`timescale 1ns/1ps
module tb_ifft_dac_playback;
    localparam int FFT_LEN   = 256;
    localparam int IN_WIDTH  = 16;
    localparam int DAC_WIDTH = 12;
    localparam int SHIFT     = 4;
    localparam logic [11:0] MID = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] dac_data;
    logic        active;
    logic [15:0] frame_count;
    logic        len_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame [FFT_LEN];
    logic [11:0] exp_q [$];
    logic [11:0] obs [$];
    logic [11:0] frame1_exp [FFT_LEN];

    ifft_dac_playback_if #(.IN_WIDTH(IN_WIDTH)) s_axis ();

    ifft_dac_playback #(
        .FFT_LEN(FFT_LEN), .IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .enable(enable),
        .dac_data(dac_data), .active(active), .frame_count(frame_count), .len_err(len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // Floor-division reference for round/shift/saturate/offset conversion.
    function automatic logic [11:0] model_conv(input int x);
        int num, t, d;
        d   = 1 << SHIFT;
        num = x + (1 << (SHIFT - 1));
        if (num >= 0) t = num / d;
        else          t = -((-num + d - 1) / d);
        if (t > 2047)  t = 2047;
        if (t < -2048) t = -2048;
        return 12'(t + 2048);
    endfunction

    task automatic send_frame(input int len, input bit last_flag);
        int waitc;
        for (int i = 0; i < len; i++) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = {16'hA5A5, 16'(frame[i])};
            s_axis.tlast  = last_flag && (i == len - 1);
            waitc = 0;
            while (s_axis.tready !== 1'b1 && waitc < 4 * FFT_LEN) begin
                @(negedge clk);
                waitc++;
            end
            checks++;
            if (waitc >= 4 * FFT_LEN) begin
                errors++;
                $display("FAIL tready_timeout: sample %0d tready=%b required 1", i, s_axis.tready);
            end
            @(negedge clk);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (dac_data !== MID)      begin errors++; $display("FAIL rst_dac: got %h want %h", dac_data, MID); end
        checks++; if (active !== 1'b0)       begin errors++; $display("FAIL rst_active: got %b want 0", active); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_fcount: got %0d want 0", frame_count); end
        checks++; if (len_err !== 1'b0)      begin errors++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_axis.tready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL tready_after_rst: got %b want 1", s_axis.tready); end
        checks++; if (dac_data !== MID)      begin errors++; $display("FAIL dac_after_rst: got %h want %h", dac_data, MID); end
    endtask

    task automatic test_first_frame();
        logic [11:0] head [7];
        logic [11:0] e;
        head = '{12'h800, 12'h801, 12'h7FF, 12'hFFF, 12'h000, 12'h801, 12'h7FF};
        for (int i = 0; i < FFT_LEN; i++) frame[i] = 0;
        frame[1] = 16; frame[2] = -16; frame[3] = 32767; frame[4] = -32768; frame[5] = 8; frame[6] = -9;
        for (int i = 0; i < FFT_LEN; i++) frame1_exp[i] = (i < 7) ? head[i] : 12'h800;
        send_frame(FFT_LEN, 1'b1);
        checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL tready_after_tlast: got %b want 0", s_axis.tready); end
        @(negedge clk);
        checks++; if (active !== 1'b1)       begin errors++; $display("FAIL active_after_swap: got %b want 1", active); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL fcount_first: got %0d want 1", frame_count); end
        checks++; if (dac_data !== MID)      begin errors++; $display("FAIL first_latency_1: got %h want %h", dac_data, MID); end
        @(negedge clk);
        checks++; if (dac_data !== MID)      begin errors++; $display("FAIL first_latency_2: got %h want %h", dac_data, MID); end
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < FFT_LEN; i++) exp_q.push_back(frame1_exp[i]);
        for (int i = 0; i < 2 * FFT_LEN; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (dac_data !== e) begin errors++; $display("FAIL first_play[%0d]: got %h want %h", i, dac_data, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int c0, hs_idx, s;
        logic [11:0] e;
        for (int i = 0; i < FFT_LEN; i++) frame[i] = 160;
        obs.delete();
        c0 = cyc; hs_idx = 0;
        fork
            begin
                send_frame(FFT_LEN, 1'b1);
                hs_idx = cyc - c0;
                checks++;
                if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL b2b_tready_after_tlast: got %b want 0", s_axis.tready); end
            end
            begin
                repeat (3 * FFT_LEN + 8) begin
                    obs.push_back(dac_data);
                    @(negedge clk);
                end
            end
        join
        s = -1;
        for (int j = 0; j < obs.size(); j++)
            if (s < 0 && obs[j] === 12'h80A) s = j;
        checks++;
        if (s < FFT_LEN || s + FFT_LEN > obs.size()) begin
            errors++; $display("FAIL b2b_switch_found: switch index %0d outside window", s);
        end else begin
            checks++;
            if (s < hs_idx + 3 || s > hs_idx + FFT_LEN + 3) begin
                errors++; $display("FAIL b2b_switch_time: switch at %0d, tlast at %0d", s, hs_idx);
            end
            for (int j = 0; j < FFT_LEN; j++) exp_q.push_back(frame1_exp[j]);
            for (int j = 0; j < FFT_LEN; j++) exp_q.push_back(model_conv(160));
            for (int j = s - FFT_LEN; j < s + FFT_LEN; j++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[j] !== e) begin errors++; $display("FAIL b2b_seq[%0d]: got %h want %h", j - s, obs[j], e); end
            end
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL fcount_second: got %0d want 2", frame_count); end
    endtask

    task automatic test_len_err();
        int waitc;
        bit stray;
        logic [11:0] e;
        for (int i = 0; i < 11; i++) frame[i] = 1000;
        send_frame(11, 1'b1);
        checks++; if (len_err !== 1'b1)      begin errors++; $display("FAIL len_err_set: got %b want 1", len_err); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL len_err_no_swap: got %0d want 2", frame_count); end
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL len_err_tready: got %b want 1", s_axis.tready); end
        for (int i = 0; i < FFT_LEN; i++) frame[i] = (i + 1) * 16;
        send_frame(FFT_LEN, 1'b1);
        waitc = 0;
        while (frame_count === 16'd2 && waitc < 2 * FFT_LEN) begin @(negedge clk); waitc++; end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL len_err_fcount: got %0d want 3", frame_count); end
        checks++; if (len_err !== 1'b1)      begin errors++; $display("FAIL len_err_sticky: got %b want 1", len_err); end
        waitc = 0; stray = 1'b0;
        while (dac_data !== model_conv(frame[0]) && waitc < 2 * FFT_LEN) begin
            if (dac_data !== 12'h80A) stray = 1'b1;
            @(negedge clk); waitc++;
        end
        checks++;
        if (stray || waitc >= 2 * FFT_LEN) begin
            errors++; $display("FAIL len_err_handover: stray=%b wait=%0d, want only 80A before ramp", stray, waitc);
        end
        for (int i = 0; i < FFT_LEN; i++) exp_q.push_back(model_conv(frame[i]));
        for (int i = 0; i < FFT_LEN; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (dac_data !== e) begin errors++; $display("FAIL ramp_play[%0d]: got %h want %h", i, dac_data, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_toggle();
        int waitc;
        logic [11:0] e;
        waitc = 0;
        while (dac_data !== model_conv(frame[98]) && waitc < 2 * FFT_LEN) begin @(negedge clk); waitc++; end
        checks++; if (waitc >= 2 * FFT_LEN) begin errors++; $display("FAIL en_sync: sample 98 never seen, dac=%h", dac_data); end
        enable = 1'b0;
        exp_q.push_back(model_conv(frame[99]));
        for (int i = 0; i < 6; i++) exp_q.push_back(MID);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (dac_data !== e) begin errors++; $display("FAIL en_low[%0d]: got %h want %h", i, dac_data, e); end
        end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL en_low_active: got %b want 1", active); end
        enable = 1'b1;
        exp_q.push_back(MID);
        for (int i = 0; i < 10; i++) exp_q.push_back(model_conv(frame[i]));
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (dac_data !== e) begin errors++; $display("FAIL en_high[%0d]: got %h want %h", i, dac_data, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        for (int i = 0; i < 20; i++) frame[i] = 5000;
        send_frame(20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dac_data !== MID)      begin errors++; $display("FAIL mid_rst_dac: got %h want %h", dac_data, MID); end
        checks++; if (active !== 1'b0)       begin errors++; $display("FAIL mid_rst_active: got %b want 0", active); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_rst_fcount: got %0d want 0", frame_count); end
        checks++; if (len_err !== 1'b0)      begin errors++; $display("FAIL mid_rst_len_err: got %b want 0", len_err); end
        checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b want 0", s_axis.tready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL mid_rel_tready: got %b want 1", s_axis.tready); end
        checks++; if (active !== 1'b0)       begin errors++; $display("FAIL mid_rel_active: got %b want 0", active); end
        for (int i = 0; i < FFT_LEN; i++) frame[i] = -(i + 1) * 16;
        send_frame(FFT_LEN, 1'b1);
        exp_q.push_back(MID);
        exp_q.push_back(MID);
        for (int i = 0; i < FFT_LEN; i++) exp_q.push_back(model_conv(frame[i]));
        for (int i = 0; i < FFT_LEN + 2; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (dac_data !== e) begin errors++; $display("FAIL post_rst_play[%0d]: got %h want %h", i, dac_data, e); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL post_rst_fcount: got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_len_err();
        test_enable_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
